// File: rtl/mult_unit_pkg.sv
// Shared types and constants for the iterative execute-stage multiplier.
package mult_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int MULT_WIDTH          = 32;
  localparam int MULT_BITS_PER_CYCLE = 2;

  function automatic int mult_iters(input int width, input int bits_per_cycle);
    return width / bits_per_cycle;
  endfunction

  // Number of CALC cycles at the default configuration; hazard-unit checks key off this.
  localparam int MULT_ITERS = mult_iters(MULT_WIDTH, MULT_BITS_PER_CYCLE);

endpackage

// File: rtl/mult_unit_if.sv
// Request/response bundle between the execute stage and the multiplier.
interface mult_unit_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic             flush;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_a;
  logic             signed_b;
  logic             high;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, flush, a, b, signed_a, signed_b, high,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, a, b, signed_a, signed_b, high,
    output busy, done, result
  );

endinterface

// File: rtl/mult_unit.sv
// Iterative shift-add multiplier (MUL/MULH/MULHSU/MULHU) retiring BITS_PER_CYCLE
// multiplier bits per cycle on operand magnitudes, sign applied once at the end.
module mult_unit
  import mult_unit_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  mult_unit_if.slave  bus
);

  localparam int ITERS = WIDTH / BITS_PER_CYCLE;
  localparam int PW    = 2 * WIDTH;
  localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;

  generate
    if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_bits_per_cycle
      $error("mult_unit: BITS_PER_CYCLE must divide WIDTH");
    end
  endgenerate

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic            is_signed);
    return (is_signed && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  endfunction

  mult_state_t      state;
  mult_state_t      state_nxt;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             neg;
  logic             high_sel;
  logic [WIDTH-1:0] result_reg;

  logic             launch;
  logic             last_iter;
  logic [PW-1:0]    partial;
  logic [PW-1:0]    acc_sum;
  logic [PW-1:0]    product;

  // A new operation may be accepted from IDLE or straight out of DONE.
  assign launch    = bus.start && !bus.flush && (state == IDLE || state == DONE);
  assign last_iter = (cnt == CW'(ITERS - 1));

  // mcand is pre-shifted each cycle, so the low multiplier bits weight it directly.
  always_comb begin
    partial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier[i]) begin
        partial = partial + (mcand << i);
      end
    end
    acc_sum = acc + partial;
    product = neg ? (~acc_sum + PW'(1)) : acc_sum;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = CALC;
      CALC:    if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = launch ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
      neg        <= 1'b0;
      high_sel   <= 1'b0;
      result_reg <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        mcand    <= PW'(magnitude(bus.a, bus.signed_a));
        mplier   <= magnitude(bus.b, bus.signed_b);
        neg      <= (bus.signed_a & bus.a[WIDTH-1]) ^ (bus.signed_b & bus.b[WIDTH-1]);
        high_sel <= bus.high;
        acc      <= '0;
        cnt      <= '0;
      end else if (state == CALC && !bus.flush) begin
        acc    <= acc_sum;
        mcand  <= mcand << BITS_PER_CYCLE;
        mplier <= mplier >> BITS_PER_CYCLE;
        cnt    <= cnt + CW'(1);
        if (last_iter) begin
          result_reg <= high_sel ? product[PW-1:WIDTH] : product[WIDTH-1:0];
        end
      end
    end
  end

  // busy covers the launch cycle combinationally so decode stalls immediately.
  assign bus.busy   = (state == CALC) || (state == IDLE && bus.start && !bus.flush);
  assign bus.done   = (state == DONE);
  assign bus.result = result_reg;

endmodule

// File: tb/tb_mult_unit.sv
// Directed and randomized checks of mult_unit against a 64-bit arithmetic reference.
module tb_mult_unit;
  import mult_unit_pkg::*;

  localparam int LAT = MULT_ITERS + 1;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mult_unit_if #(.WIDTH(32)) bus ();

  mult_unit #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: extend each operand per its signedness and multiply modulo 2^64.
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic sx, input logic sy, input logic h);
    logic [63:0] ex, ey, p;
    ex = sx ? {{32{x[31]}}, x} : {32'b0, x};
    ey = sy ? {{32{y[31]}}, y} : {32'b0, y};
    p  = ex * ey;
    return h ? p[63:32] : p[31:0];
  endfunction

  task automatic drive(input logic [31:0] x, input logic [31:0] y,
                       input logic sx, input logic sy, input logic h);
    bus.a        = x;
    bus.b        = y;
    bus.signed_a = sx;
    bus.signed_b = sy;
    bus.high     = h;
  endtask

  // Called at a negedge where done is already high: one pulse only, result held.
  task automatic check_pulse_end(input string tag, input logic [31:0] exp);
    @(negedge clk);
    check({tag, "_done_pulse"}, {63'b0, bus.done}, 64'd0);
    check({tag, "_held"}, {32'b0, bus.result}, {32'b0, exp});
  endtask

  // Waits for done starting one edge after launch; returns edges counted and busy cycles.
  task automatic wait_done(output int cyc, inout int busy_cnt);
    cyc = 1;
    while (!bus.done && cyc < 60) begin
      busy_cnt += bus.busy ? 1 : 0;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic sx, input logic sy, input logic h, input logic [31:0] exp);
    int cyc;
    int busy_cnt;
    @(negedge clk);
    drive(x, y, sx, sy, h);
    bus.start = 1'b1;
    #1;
    busy_cnt = bus.busy ? 1 : 0;
    @(negedge clk);
    bus.start = 1'b0;
    drive($urandom, $urandom, 1'b0, 1'b0, 1'b0);
    wait_done(cyc, busy_cnt);
    check({tag, "_latency"}, 64'(cyc), 64'(LAT));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(LAT));
    check({tag, "_busy_in_done"}, {63'b0, bus.busy}, 64'd0);
    check({tag, "_result"}, {32'b0, bus.result}, {32'b0, exp});
    check_pulse_end(tag, exp);
  endtask

  initial begin
    int          cyc;
    int          busy_cnt;
    int          seen_done;
    logic [31:0] ra, rb, exp, prev;
    logic        rsa, rsb, rh;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_busy", {63'b0, bus.busy}, 64'd0);
    check("reset_done", {63'b0, bus.done}, 64'd0);
    check("reset_result", {32'b0, bus.result}, 64'd0);
    rst = 1'b0;

    run_op("mul_7x6", 32'd7, 32'd6, 1'b0, 1'b0, 1'b0, 32'h0000002A);
    run_op("mul_m3x5", 32'hFFFFFFFD, 32'd5, 1'b1, 1'b1, 1'b0, 32'hFFFFFFF1);
    run_op("mulh_m3x5", 32'hFFFFFFFD, 32'd5, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF);
    run_op("mulh_min_sq", 32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b1, 32'h40000000);
    run_op("mul_min_sq", 32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b0, 32'h00000000);
    run_op("mulhu_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE);
    run_op("mulhsu_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF);
    run_op("mulh_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 32'h00000000);

    // Flush on the 8th CALC cycle: no done, result keeps the previous value.
    prev = bus.result;
    @(negedge clk);
    drive(32'd7, 32'd6, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy_drop", {63'b0, bus.busy}, 64'd0);
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      seen_done += bus.done ? 1 : 0;
      @(negedge clk);
    end
    check("flush_no_done", 64'(seen_done), 64'd0);
    check("flush_result_kept", {32'b0, bus.result}, {32'b0, prev});
    run_op("after_flush_2x3", 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 32'd6);

    // start and flush in the same IDLE cycle must not launch.
    @(negedge clk);
    drive(32'd11, 32'd11, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    #1;
    check("start_flush_busy", {63'b0, bus.busy}, 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      seen_done += (bus.done || bus.busy) ? 1 : 0;
      @(negedge clk);
    end
    check("start_flush_no_launch", 64'(seen_done), 64'd0);

    // Back-to-back: start held into the DONE cycle with fresh operands.
    @(negedge clk);
    drive(32'd5, 32'd4, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    busy_cnt = 0;
    wait_done(cyc, busy_cnt);
    check("b2b_first_result", {32'b0, bus.result}, 64'd20);
    drive(32'd9, 32'd9, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    bus.flush = 1'b0;
    #1;
    check("b2b_busy_in_done", {63'b0, bus.busy}, 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    busy_cnt = 0;
    wait_done(cyc, busy_cnt);
    check("b2b_latency", 64'(cyc), 64'(LAT));
    check("b2b_result", {32'b0, bus.result}, 64'd81);
    // flush landing in the DONE cycle leaves that done pulse intact.
    bus.flush = 1'b1;
    #1;
    check("flush_in_done_keeps_pulse", {63'b0, bus.done}, 64'd1);
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_in_done_result", {32'b0, bus.result}, 64'd81);

    for (int n = 0; n < 24; n++) begin
      ra  = $urandom;
      rb  = $urandom;
      rsa = 1'($urandom_range(1));
      rsb = 1'($urandom_range(1));
      rh  = 1'($urandom_range(1));
      exp = ref_mul(ra, rb, rsa, rsb, rh);
      run_op($sformatf("rand%0d", n), ra, rb, rsa, rsb, rh, exp);
    end

    // Reset in the middle of CALC clears everything and yields no done.
    @(negedge clk);
    drive(32'h1234, 32'h5678, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_busy", {63'b0, bus.busy}, 64'd0);
    check("midreset_done", {63'b0, bus.done}, 64'd0);
    check("midreset_result", {32'b0, bus.result}, 64'd0);
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      seen_done += bus.done ? 1 : 0;
      @(negedge clk);
    end
    check("midreset_no_done", 64'(seen_done), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
